ps2_note_decoder: RTL
=====================

Name: ps2_note_decoder

Overview:
Converts the PS/2 scan-code byte stream from the keyboard receiver into synth control: held-key mask, mono note with last-key priority, gate, and saturating octave and amplitude registers. Supersedes the single-byte case decoder. Adds make/break (F0) and extended (E0) prefix handling, typematic-repeat suppression, and parametrised octave/amplitude ranges. Sits between the PS/2 receiver and the oscillator/envelope blocks, entirely in the CLOCK_50 domain.

Parameters:
OCT_W, 3, octave register width
OCT_MIN, 0, lowest octave value
OCT_MAX, 7, highest octave value
OCT_INIT, 4, octave value after reset
AMP_W, 4, amplitude register width
AMP_MIN, 0, lowest amplitude value
AMP_MAX, 15, highest amplitude value
AMP_INIT, 8, amplitude value after reset

Ports:
CLOCK_50  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
byte_valid  in  1  one-cycle strobe: byte_in holds a new received scan-code byte
byte_in  in  8  received scan-code byte
key_held  out  12  bit i = note i (C=0 … B=11) currently held
note  out  4  current mono note, 0–11
gate  out  1  high while any note key is held (|key_held)
note_on  out  1  one-cycle pulse on a new, non-repeat note make
octave  out  OCT_W  current octave
amplitude  out  AMP_W  current amplitude

Behaviour:
- Reset values: key_held=0, note=0, gate=0, note_on=0, octave=OCT_INIT, amplitude=AMP_INIT, FSM=IDLE, ctrl_held=0.
- Key map (set-2 make codes): 1C→0, 1D→1, 1B→2, 24→3, 23→4, 2B→5, 2C→6, 34→7, 35→8, 33→9, 3C→10, 3B→11. Control keys: 1A octave down, 22 octave up, 16 amplitude down, 1E amplitude up. All other codes are ignored.
- Prefix FSM advances only on byte_valid:
  - IDLE: F0→BREAK; E0→EXT; else process byte as a make, stay IDLE.
  - BREAK: process byte as a break→IDLE.
  - EXT: F0→EXT_BREAK; else discard byte→IDLE.
  - EXT_BREAK: discard byte→IDLE.
  - An E0 or F0 byte arriving in BREAK or EXT_BREAK is discarded and the FSM returns to IDLE.
- Latency: all register effects of a byte are visible on the cycle after byte_valid. note_on is high for exactly that one cycle.
- Note make:
  - If key_held[i]=0: set the bit, set note=i, pulse note_on.
  - If key_held[i]=1 (typematic repeat): no change, no pulse.
- Note break, clear key_held[i]:
  - If i==note and other keys are still held: note = lowest-index remaining held key, no note_on.
  - If no keys remain: note keeps its value and gate falls.
  - Break for a key not held: no effect.
- Control keys:
  - 4-bit ctrl_held tracks the control keys so that repeats are suppressed.
  - A make with ctrl_held bit clear sets the bit and steps the register by ±1. The step saturates at OCT_MIN/OCT_MAX or AMP_MIN/AMP_MAX: no wrap.
  - A make with the bit already set does nothing. The matching break clears the bit.
- gate is combinational from key_held (no added latency beyond key_held).
- byte_valid high on consecutive cycles is legal: each cycle is one byte.
- Asserting reset mid-sequence (e.g. in BREAK) returns every register to its reset value immediately. The next byte is parsed from IDLE.

Test Plan:
- Reset, then bytes 1C, F0, 1C → after 1C: key_held=001h, note=0, gate=1, note_on pulses 1 cycle. After break: key_held=0, gate=0, note=0.
- Bytes 1C, 1C, 1C (typematic) → exactly one note_on pulse; key_held=001h throughout.
- Make 1C, make 33, break 33 → note goes 0→9→0; key_held goes 001h→201h→001h; gate stays 1; two note_on pulses total.
- Octave from 4: six (22, F0, 22) pairs → octave 5,6,7,7,7,7. Then nine (1A, F0, 1A) pairs → ends at 0, no wrap. Holding 1E with three repeats → amplitude 8→9 only.
- Extended: E0, 1C, then E0, F0, 1C → no state change; FSM back in IDLE; a following 1B gives note=2.
- Reset asserted one cycle after F0 → all outputs at reset values. A following 1C is treated as a make: key_held=001h.

Source files
------------

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder
// Turns the PS/2 set-2 scan-code byte stream into synth control. It tracks the
// held note keys, picks a mono note (the last key pressed wins), drives a gate,
// and keeps saturating octave and amplitude registers. The decoder handles the
// F0 (break) and E0 (extended) prefixes and ignores typematic repeats.
// All logic runs on the rising edge of CLOCK_50.

module ps2_note_decoder #(
   parameter int OCT_W    = 3,
   parameter int OCT_MIN  = 0,
   parameter int OCT_MAX  = 7,
   parameter int OCT_INIT = 4,
   parameter int AMP_W    = 4,
   parameter int AMP_MIN  = 0,
   parameter int AMP_MAX  = 15,
   parameter int AMP_INIT = 8
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             byte_valid,
   input  logic [7:0]       byte_in,
   output logic [11:0]      key_held,
   output logic [3:0]       note,
   output logic             gate,
   output logic             note_on,
   output logic [OCT_W-1:0] octave,
   output logic [AMP_W-1:0] amplitude
);

   // Prefix parser states.
   typedef enum logic [1:0] {
      IDLE,
      BREAK,
      EXT,
      EXT_BREAK
   } state_t;

   // Control-key slots inside ctrl_held.
   localparam int CTRL_OCT_DN = 0;
   localparam int CTRL_OCT_UP = 1;
   localparam int CTRL_AMP_DN = 2;
   localparam int CTRL_AMP_UP = 3;

   localparam logic [7:0] CODE_BREAK = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;

   localparam logic [OCT_W-1:0] OCT_LO = OCT_W'(OCT_MIN);
   localparam logic [OCT_W-1:0] OCT_HI = OCT_W'(OCT_MAX);
   localparam logic [AMP_W-1:0] AMP_LO = AMP_W'(AMP_MIN);
   localparam logic [AMP_W-1:0] AMP_HI = AMP_W'(AMP_MAX);

   state_t      state;
   logic [3:0]  ctrl_held;

   logic        is_note;
   logic [3:0]  note_idx;
   logic        is_ctrl;
   logic [1:0]  ctrl_idx;
   logic        is_prefix;
   logic        do_make;
   logic        do_break;
   logic [11:0] remain;
   logic [3:0]  low_idx;

   // Decode the current byte into a note index or a control-key slot.
   always_comb begin
      // NOTE: every output of this block gets a default first, so that no
      // path through the case leaves it unassigned and infers a latch.
      is_note  = 1'b1;
      note_idx = 4'd0;
      is_ctrl  = 1'b0;
      ctrl_idx = 2'd0;
      case (byte_in)
         8'h1C: note_idx = 4'd0;
         8'h1D: note_idx = 4'd1;
         8'h1B: note_idx = 4'd2;
         8'h24: note_idx = 4'd3;
         8'h23: note_idx = 4'd4;
         8'h2B: note_idx = 4'd5;
         8'h2C: note_idx = 4'd6;
         8'h34: note_idx = 4'd7;
         8'h35: note_idx = 4'd8;
         8'h33: note_idx = 4'd9;
         8'h3C: note_idx = 4'd10;
         8'h3B: note_idx = 4'd11;
         8'h1A: begin is_note = 1'b0; is_ctrl = 1'b1; ctrl_idx = 2'(CTRL_OCT_DN); end
         8'h22: begin is_note = 1'b0; is_ctrl = 1'b1; ctrl_idx = 2'(CTRL_OCT_UP); end
         8'h16: begin is_note = 1'b0; is_ctrl = 1'b1; ctrl_idx = 2'(CTRL_AMP_DN); end
         8'h1E: begin is_note = 1'b0; is_ctrl = 1'b1; ctrl_idx = 2'(CTRL_AMP_UP); end
         default: is_note = 1'b0;
      endcase
   end

   // Decide whether this byte acts as a make or a break in the current state.
   always_comb begin
      is_prefix = (byte_in == CODE_BREAK) || (byte_in == CODE_EXT);
      do_make   = byte_valid && (state == IDLE)  && !is_prefix;
      do_break  = byte_valid && (state == BREAK) && !is_prefix;
   end

   // Find the lowest held key left after the key named by this byte is released.
   always_comb begin
      remain  = key_held & ~(12'd1 << note_idx);
      low_idx = 4'd0;
      for (int i = 11; i >= 0; i--) begin
         if (remain[i]) low_idx = 4'(i);
      end
   end

   assign gate = |key_held;

   // Prefix FSM plus every registered output. One byte takes effect per valid cycle.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         key_held  <= 12'd0;
         note      <= 4'd0;
         note_on   <= 1'b0;
         ctrl_held <= 4'd0;
         octave    <= OCT_W'(OCT_INIT);
         amplitude <= AMP_W'(AMP_INIT);
      end else begin
         // NOTE: state is updated with non-blocking assignments, so every
         // decision in this block sees the values from before this edge.
         note_on <= 1'b0;

         if (byte_valid) begin
            case (state)
               IDLE: begin
                  if (byte_in == CODE_BREAK)    state <= BREAK;
                  else if (byte_in == CODE_EXT) state <= EXT;
                  else                          state <= IDLE;
               end
               BREAK:     state <= IDLE;
               EXT:       state <= (byte_in == CODE_BREAK) ? EXT_BREAK : IDLE;
               EXT_BREAK: state <= IDLE;
               default:   state <= IDLE;
            endcase
         end

         // A note make that is not a typematic repeat takes over the mono note.
         if (do_make && is_note && !key_held[note_idx]) begin
            key_held[note_idx] <= 1'b1;
            note               <= note_idx;
            note_on            <= 1'b1;
         end

         // Releasing the sounding note falls back to the lowest key still held.
         // If no key remains, note keeps its value and only the gate drops.
         if (do_break && is_note && key_held[note_idx]) begin
            key_held[note_idx] <= 1'b0;
            if ((note_idx == note) && (remain != 12'd0)) note <= low_idx;
         end

         // The first make of a control key steps its register and saturates at the limits.
         if (do_make && is_ctrl && !ctrl_held[ctrl_idx]) begin
            ctrl_held[ctrl_idx] <= 1'b1;
            case (ctrl_idx)
               2'(CTRL_OCT_DN): if (octave    > OCT_LO) octave    <= octave    - OCT_W'(1);
               2'(CTRL_OCT_UP): if (octave    < OCT_HI) octave    <= octave    + OCT_W'(1);
               2'(CTRL_AMP_DN): if (amplitude > AMP_LO) amplitude <= amplitude - AMP_W'(1);
               default:         if (amplitude < AMP_HI) amplitude <= amplitude + AMP_W'(1);
            endcase
         end

         if (do_break && is_ctrl) ctrl_held[ctrl_idx] <= 1'b0;
      end
   end

endmodule
